// File: rtl/eqcheck_pkg.sv
// rtl/eqcheck_pkg.sv - shared types and helpers for the pipelined equivalence checker
package eqcheck_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } eqcheck_state_t;

    localparam int SAT_MAX_WIDTH = 64;

    // Increment that sticks at the all-ones value of a counter 'width' bits wide.
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(input logic [SAT_MAX_WIDTH-1:0] value,
                                                         input int width);
        logic [SAT_MAX_WIDTH-1:0] max_val;
        max_val = (width >= SAT_MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - fixed-depth registered shift of {valid,last,data}
module valid_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic             out_last,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst};
            assign out_valid = in_valid;
            assign out_last  = in_last;
            assign out_data  = in_data;
        end else begin : g_pipe
            logic [DEPTH-1:0] valid_q;
            logic [DEPTH-1:0] last_q;
            logic [WIDTH-1:0] data_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= '0;
                    last_q  <= '0;
                end else begin
                    valid_q[0] <= in_valid;
                    last_q[0]  <= in_last;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        last_q[i]  <= last_q[i-1];
                    end
                end
            end

            // Data is only meaningful alongside a valid bit, so it needs no reset.
            always_ff @(posedge clk) begin
                data_q[0] <= in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    data_q[i] <= data_q[i-1];
                end
            end

            assign out_valid = valid_q[DEPTH-1];
            assign out_last  = last_q[DEPTH-1];
            assign out_data  = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pipelined_equivalence_checker.sv
// rtl/pipelined_equivalence_checker.sv - aligns input vectors to module outputs and tallies compares
module pipelined_equivalence_checker
    import eqcheck_pkg::*;
#(
    parameter int IN_WIDTH       = 2,
    parameter int OUT_WIDTH      = 1,
    parameter int PIPELINE_DEPTH = 0,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_vec,
    input  logic                 in_last,
    input  logic [OUT_WIDTH-1:0] out_test,
    input  logic [OUT_WIDTH-1:0] out_ground_truth,
    output logic [CNT_WIDTH-1:0] checked_count,
    output logic [CNT_WIDTH-1:0] mismatch_count,
    output logic                 first_mismatch_valid,
    output logic [IN_WIDTH-1:0]  first_mismatch_inputs,
    output logic [OUT_WIDTH-1:0] first_mismatch_test,
    output logic [OUT_WIDTH-1:0] first_mismatch_gt,
    output logic                 done,
    output logic                 pass
);

    logic                a_valid;
    logic                a_last;
    logic [IN_WIDTH-1:0] a_vec;

    eqcheck_state_t state;
    eqcheck_state_t next_state;
    logic           compare;
    logic           mismatch;

    valid_delay_line #(
        .WIDTH (IN_WIDTH),
        .DEPTH (PIPELINE_DEPTH)
    ) u_align (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_vec),
        .out_valid (a_valid),
        .out_last  (a_last),
        .out_data  (a_vec)
    );

    assign compare  = a_valid && (state != ST_DONE);
    assign mismatch = (out_test != out_ground_truth);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (compare) next_state = a_last ? ST_DONE : ST_RUN;
            ST_RUN:  if (compare && a_last) next_state = ST_DONE;
            ST_DONE: next_state = ST_DONE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counters and capture freeze once DONE because compare is gated by the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            checked_count         <= '0;
            mismatch_count        <= '0;
            first_mismatch_valid  <= 1'b0;
            first_mismatch_inputs <= '0;
            first_mismatch_test   <= '0;
            first_mismatch_gt     <= '0;
        end else if (compare) begin
            checked_count <= CNT_WIDTH'(sat_inc(64'(checked_count), CNT_WIDTH));
            if (mismatch) begin
                mismatch_count <= CNT_WIDTH'(sat_inc(64'(mismatch_count), CNT_WIDTH));
                if (!first_mismatch_valid) begin
                    first_mismatch_valid  <= 1'b1;
                    first_mismatch_inputs <= a_vec;
                    first_mismatch_test   <= out_test;
                    first_mismatch_gt     <= out_ground_truth;
                end
            end
        end
    end

    assign done = (state == ST_DONE);
    assign pass = done && (mismatch_count == '0);

endmodule

// File: tb/tb_pipelined_equivalence_checker.sv
// tb/tb_pipelined_equivalence_checker.sv - randomized self-checking bench for three checker configurations
module tb_pipelined_equivalence_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic [1:0] in_vec;
    logic       fault0, fault2, faultc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] va  [16];
    bit         f0a [16];
    bit         f2a [16];
    bit         fca [16];
    int         nv;

    // Compared logic: AND as ground truth, De Morgan form as the test side, fault flips it.
    logic [1:0] d_vec [2];
    logic       d_f   [2];
    logic out_gt0, out_test0, out_gt2, out_test2, out_gtc, out_testc;

    assign out_gt0   = in_vec[1] & in_vec[0];
    assign out_test0 = ~(~in_vec[1] | ~in_vec[0]) ^ fault0;
    assign out_gtc   = in_vec[1] & in_vec[0];
    assign out_testc = ~(~in_vec[1] | ~in_vec[0]) ^ faultc;
    assign out_gt2   = d_vec[1][1] & d_vec[1][0];
    assign out_test2 = ~(~d_vec[1][1] | ~d_vec[1][0]) ^ d_f[1];

    always @(posedge clk) begin
        d_vec[0] <= in_vec;
        d_f[0]   <= fault2;
        d_vec[1] <= d_vec[0];
        d_f[1]   <= d_f[0];
    end

    logic [31:0] chk0, mm0, chk2, mm2;
    logic [1:0]  chkc, mmc;
    logic        fv0, fv2, fvc, ft0, ft2, ftc, fg0, fg2, fgc;
    logic [1:0]  fi0, fi2, fic;
    logic        dn0, dn2, dnc, ps0, ps2, psc;

    pipelined_equivalence_checker #(.IN_WIDTH(2), .OUT_WIDTH(1), .PIPELINE_DEPTH(0), .CNT_WIDTH(32)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec), .in_last(in_last),
        .out_test(out_test0), .out_ground_truth(out_gt0),
        .checked_count(chk0), .mismatch_count(mm0), .first_mismatch_valid(fv0),
        .first_mismatch_inputs(fi0), .first_mismatch_test(ft0), .first_mismatch_gt(fg0),
        .done(dn0), .pass(ps0));

    pipelined_equivalence_checker #(.IN_WIDTH(2), .OUT_WIDTH(1), .PIPELINE_DEPTH(2), .CNT_WIDTH(32)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec), .in_last(in_last),
        .out_test(out_test2), .out_ground_truth(out_gt2),
        .checked_count(chk2), .mismatch_count(mm2), .first_mismatch_valid(fv2),
        .first_mismatch_inputs(fi2), .first_mismatch_test(ft2), .first_mismatch_gt(fg2),
        .done(dn2), .pass(ps2));

    pipelined_equivalence_checker #(.IN_WIDTH(2), .OUT_WIDTH(1), .PIPELINE_DEPTH(0), .CNT_WIDTH(2)) dutc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec), .in_last(in_last),
        .out_test(out_testc), .out_ground_truth(out_gtc),
        .checked_count(chkc), .mismatch_count(mmc), .first_mismatch_valid(fvc),
        .first_mismatch_inputs(fic), .first_mismatch_test(ftc), .first_mismatch_gt(fgc),
        .done(dnc), .pass(psc));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [1:0] vec,
                         input bit a, input bit b, input bit c);
        @(negedge clk);
        in_valid = v;
        in_last  = l;
        in_vec   = vec;
        fault0   = a;
        fault2   = b;
        faultc   = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        fault0   = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        fault0   = 1'b0;
    endtask

    task automatic expect_reset(input string tag);
        expect_eq({tag, ".chk0"}, 64'(chk0), 0);
        expect_eq({tag, ".mm0"},  64'(mm0),  0);
        expect_eq({tag, ".fv0"},  64'(fv0),  0);
        expect_eq({tag, ".dn0"},  64'(dn0),  0);
        expect_eq({tag, ".ps0"},  64'(ps0),  0);
        expect_eq({tag, ".chk2"}, 64'(chk2), 0);
        expect_eq({tag, ".dn2"},  64'(dn2),  0);
        expect_eq({tag, ".chkc"}, 64'(chkc), 0);
        expect_eq({tag, ".fvc"},  64'(fvc),  0);
        expect_eq({tag, ".dnc"},  64'(dnc),  0);
    endtask

    // Expected results of a completed run follow from the vector list alone.
    task automatic expect_inst(input string tag, input longint sat, input bit f [16],
                               input logic [31:0] chk, input logic [31:0] mm, input logic fv,
                               input logic [1:0] fi, input logic ft, input logic fg,
                               input logic dn, input logic ps);
        int cnt = 0;
        int first = -1;
        longint ec, em;
        logic [1:0] efi = 2'b00;
        logic efg = 1'b0, eft = 1'b0;
        for (int i = 0; i < nv; i++) begin
            if (f[i]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        ec = (nv < sat) ? nv : sat;
        em = (cnt < sat) ? cnt : sat;
        if (first >= 0) begin
            efi = va[first];
            efg = (va[first] == 2'b11);
            eft = !efg;
        end
        expect_eq({tag, ".checked"},  64'(chk), 64'(ec));
        expect_eq({tag, ".mismatch"}, 64'(mm),  64'(em));
        expect_eq({tag, ".fm_valid"}, 64'(fv),  64'(first >= 0));
        expect_eq({tag, ".fm_in"},    64'(fi),  64'(efi));
        expect_eq({tag, ".fm_test"},  64'(ft),  64'(eft));
        expect_eq({tag, ".fm_gt"},    64'(fg),  64'(efg));
        expect_eq({tag, ".done"},     64'(dn),  1);
        expect_eq({tag, ".pass"},     64'(ps),  64'(cnt == 0));
    endtask

    task automatic verify_all(input string tag);
        expect_inst({tag, ".d0"}, 64'hFFFF_FFFF, f0a, chk0, mm0, fv0, fi0, ft0, fg0, dn0, ps0);
        expect_inst({tag, ".d2"}, 64'hFFFF_FFFF, f2a, chk2, mm2, fv2, fi2, ft2, fg2, dn2, ps2);
        expect_inst({tag, ".dc"}, 3, fca, {30'd0, chkc}, {30'd0, mmc}, fvc, fic, ftc, fgc, dnc, psc);
    endtask

    // bubble_mode: 0 none, 1 one idle cycle, 2 random 0..2 idle cycles
    task automatic run(input string tag, input int bubble_mode, input bit with_reset);
        int nb;
        if (with_reset) do_reset();
        for (int i = 0; i < nv; i++) begin
            drive(1'b1, i == nv - 1, va[i], f0a[i], f2a[i], fca[i]);
            if (i < nv - 1) begin
                nb = (bubble_mode == 0) ? 0 : (bubble_mode == 1) ? 1 : int'($urandom_range(0, 2));
                repeat (nb) idle();
            end
        end
        idle();
        expect_eq({tag, ".done0_1"}, 64'(dn0), 1);
        expect_eq({tag, ".donec_1"}, 64'(dnc), 1);
        expect_eq({tag, ".done2_1"}, 64'(dn2), 0);
        idle();
        expect_eq({tag, ".done2_2"}, 64'(dn2), 0);
        idle();
        expect_eq({tag, ".done2_3"}, 64'(dn2), 1);
        repeat (2) idle();
        verify_all(tag);
        // Differing outputs after completion must leave everything untouched.
        repeat (3) drive(1'b1, 1'($urandom), 2'($urandom), 1'b1, 1'b1, 1'b1);
        repeat (4) idle();
        verify_all({tag, ".post"});
    endtask

    task automatic clear_run(input int n);
        nv = n;
        for (int i = 0; i < 16; i++) begin
            va[i]  = 2'(i);
            f0a[i] = 1'b0;
            f2a[i] = 1'b0;
            fca[i] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_vec = 2'b00;
        fault0 = 1'b0; fault2 = 1'b0; faultc = 1'b0;
        do_reset();
        expect_reset("reset");

        clear_run(4);
        run("t1_clean", 0, 1'b1);

        clear_run(4);
        f0a[2] = 1'b1; f2a[2] = 1'b1; fca[2] = 1'b1;
        run("t2_fault10", 0, 1'b1);

        clear_run(4);
        run("t3_bubbles", 1, 1'b1);

        clear_run(4);
        f0a[1] = 1'b1; f2a[0] = 1'b1;
        do_reset();
        drive(1'b1, 1'b0, va[0], 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, va[1], 1'b1, 1'b1, 1'b1);
        do_reset();
        expect_reset("t4_midrst");
        run("t4_replay", 2, 1'b0);

        clear_run(6);
        for (int i = 0; i < 6; i++) begin
            fca[i] = 1'b1;
            f0a[i] = 1'($urandom);
        end
        run("t5_sat", 2, 1'b1);

        for (int r = 0; r < 10; r++) begin
            clear_run(int'($urandom_range(1, 12)));
            for (int i = 0; i < nv; i++) begin
                va[i]  = 2'($urandom);
                f0a[i] = ($urandom_range(0, 3) == 0);
                f2a[i] = ($urandom_range(0, 3) == 0);
                fca[i] = ($urandom_range(0, 1) == 0);
            end
            run($sformatf("rand%0d", r), 2, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
